// File: rtl/debug_trace_pkg.sv
// Shared types and helpers for the debug trace serializer.
package debug_trace_pkg;

  // Width of the per-record word-count field stored alongside each record (holds 1..4).
  localparam int unsigned WCNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } trace_state_e;

  // Words to send for a given mode: min(mode+1, num_words).
  function automatic logic [WCNT_W-1:0] clamp_words(input logic [1:0] mode,
                                                    input int unsigned num_words);
    int unsigned req;
    req = 32'(mode) + 32'd1;
    return (req < num_words) ? WCNT_W'(req) : WCNT_W'(num_words);
  endfunction

  // Output beats needed to carry one trace word.
  function automatic int unsigned beats_per_word(input int unsigned data_w,
                                                 input int unsigned out_w);
    return data_w / out_w;
  endfunction

endpackage

// File: rtl/debug_trace_serializer_if.sv
// Commit-capture and beat-stream signals of the debug trace serializer.
interface debug_trace_serializer_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 3,
  parameter int unsigned OUT_W     = 4,
  parameter int unsigned DROP_W    = 16
);
  logic                        in_valid;
  logic [NUM_WORDS*DATA_W-1:0] in_words;
  logic [1:0]                  mode;
  logic                        out_valid;
  logic [OUT_W-1:0]            out_data;
  logic                        out_last;
  logic                        out_ready;
  logic                        busy;
  logic [DROP_W-1:0]           drop_cnt;

  // Environment side: commit producer and beat sink.
  modport master (
    output in_valid, in_words, mode, out_ready,
    input  out_valid, out_data, out_last, busy, drop_cnt
  );

  // Serializer side.
  modport slave (
    input  in_valid, in_words, mode, out_ready,
    output out_valid, out_data, out_last, busy, drop_cnt
  );
endinterface

// File: rtl/debug_trace_fifo.sv
// Record queue: synchronous push/pop, pointers carry an extra wrap bit.
module debug_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (32'(count) == DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; both may move in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/debug_trace_serializer.sv
// Debug trace serializer: queues commit records and emits each as a frame of
// OUT_W-bit digits, word 0 first, least-significant digit first.
// Optional macro DEBUG_TRACE_DEDUP_EN discards records repeating the last pushed pc.
module debug_trace_serializer
  import debug_trace_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_WORDS  = 3,
  parameter int unsigned OUT_W      = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_W     = 16
) (
  input logic                     clk,
  input logic                     rst,
  debug_trace_serializer_if.slave bus
);

  localparam int unsigned BPW       = beats_per_word(DATA_W, OUT_W);
  localparam int unsigned REC_W     = NUM_WORDS * DATA_W;
  localparam int unsigned ENT_W     = WCNT_W + REC_W;
  localparam int unsigned BEATS_MAX = NUM_WORDS * BPW;
  localparam int unsigned CNT_W     = $clog2(BEATS_MAX + 1);
  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;

  trace_state_e      state;
  logic [REC_W-1:0]  sr;
  logic [REC_W-1:0]  sr_shift;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  load_cnt;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              out_last_q;
  logic              busy_q;
  logic [DROP_W-1:0] drop_q;

  logic [DATA_W-1:0] in_pc;
  logic              is_dup;
  logic              push_req;
  logic              fifo_push;
  logic              fifo_pop;
  logic              drop;
  logic [ENT_W-1:0]  fifo_wr;
  logic [ENT_W-1:0]  fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW:0]       fifo_count;
  logic [AW:0]       fifo_cnt_nxt;
  logic [WCNT_W-1:0] head_wcnt;
  logic [REC_W-1:0]  head_words;

  assign in_pc = bus.in_words[DATA_W-1:0];

`ifdef DEBUG_TRACE_DEDUP_EN
  logic [DATA_W-1:0] last_pc;

  // Remember the pc of the most recent record that entered the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_pc <= '0;
    else if (fifo_push) last_pc <= in_pc;
  end

  assign is_dup = (in_pc == last_pc);
`else
  assign is_dup = 1'b0;
`endif

  // Capture qualification: pc==0 and duplicates vanish silently; full drops are counted.
  assign push_req     = bus.in_valid && (in_pc != '0) && !is_dup;
  assign fifo_push    = push_req && !fifo_full;
  assign drop         = push_req && fifo_full;
  assign fifo_pop     = (state == LOAD);
  assign fifo_wr      = {clamp_words(bus.mode, NUM_WORDS), bus.in_words};
  assign fifo_cnt_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  assign head_wcnt  = fifo_rd[ENT_W-1 -: WCNT_W];
  assign head_words = fifo_rd[REC_W-1:0];
  assign load_cnt   = CNT_W'(32'(head_wcnt) * BPW - 32'd1);
  assign sr_shift   = sr >> OUT_W;

  debug_trace_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (fifo_wr),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Frame FSM with registered beat outputs and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      beat_cnt    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      busy_q <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= LOAD;
          else             busy_q <= (fifo_cnt_nxt != '0);
        end
        LOAD: begin
          sr          <= head_words;
          beat_cnt    <= load_cnt;
          out_valid_q <= 1'b1;
          out_data_q  <= head_words[OUT_W-1:0];
          out_last_q  <= (load_cnt == '0);
          state       <= SEND;
        end
        SEND: begin
          if (bus.out_ready) begin
            if (beat_cnt == '0) begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              busy_q      <= (fifo_cnt_nxt != '0);
            end else begin
              sr         <= sr_shift;
              out_data_q <= sr_shift[OUT_W-1:0];
              beat_cnt   <= beat_cnt - CNT_W'(1);
              out_last_q <= (beat_cnt == CNT_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of records lost to a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else if (drop && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_debug_trace_serializer.sv
// Directed self-checking bench for debug_trace_serializer (default parameters).
module tb_debug_trace_serializer;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_WORDS  = 3;
  localparam int unsigned OUT_W      = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DROP_W     = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  debug_trace_serializer_if #(
    .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .OUT_W(OUT_W), .DROP_W(DROP_W)
  ) bus ();

  debug_trace_serializer #(
    .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .OUT_W(OUT_W),
    .FIFO_DEPTH(FIFO_DEPTH), .DROP_W(DROP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [OUT_W-1:0] mon_data[$];
  logic             mon_last[$];

  // Record every beat that will transfer at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      mon_data.push_back(bus.out_data);
      mon_last.push_back(bus.out_last);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_data.delete();
    mon_last.delete();
  endtask

  task automatic push_rec(input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] wdata, input logic [1:0] md);
    bus.in_valid = 1'b1;
    bus.in_words = {wdata, instr, pc};
    bus.mode     = md;
    tick();
    bus.in_valid = 1'b0;
    bus.in_words = '0;
    bus.mode     = 2'd0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n = 0;
    while ((bus.busy || bus.out_valid) && n < budget) begin
      tick();
      n++;
    end
    timed_out = bus.busy || bus.out_valid;
  endtask

  task automatic wait_valid(input int budget, output bit timed_out);
    int n = 0;
    while (!bus.out_valid && n < budget) begin
      tick();
      n++;
    end
    timed_out = !bus.out_valid;
  endtask

  task automatic test_reset();
    n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_assert++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    n_assert++; if (bus.out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_assert++; if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", bus.drop_cnt); end
  endtask

  // pc=0x1C000000, instr=0x02800C0C, mode 1: 16 beats, first beat two cycles after capture.
  task automatic test_single();
    logic [3:0] exp [16] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 4'h1,
                             4'hC, 4'h0, 4'hC, 4'h0, 4'h0, 4'h8, 4'h2, 4'h0};
    bit to;
    mon_clear();
    bus.out_ready = 1'b1;
    push_rec(32'h1C000000, 32'h02800C0C, 32'h0, 2'd1);
    n_assert++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_after_capture got %b want 1", bus.busy); end
    n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_n0 got %b want 0", bus.out_valid); end
    tick();
    n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_n1 got %b want 0", bus.out_valid); end
    tick();
    n_assert++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_n2 got %b want 1", bus.out_valid); end
    wait_idle(100, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout got %b want 0", to); end
    n_assert++; if (mon_data.size() !== 16) begin n_fail++; $display("FAIL single_beats got %0d want 16", mon_data.size()); end
    for (int i = 0; i < 16; i++) begin
      if (i < mon_data.size()) begin
        n_assert++; if (mon_data[i] !== exp[i]) begin n_fail++; $display("FAIL single_digit[%0d] got %h want %h", i, mon_data[i], exp[i]); end
        n_assert++; if (mon_last[i] !== (i == 15)) begin n_fail++; $display("FAIL single_last[%0d] got %b want %b", i, mon_last[i], (i == 15)); end
      end
    end
  endtask

  // Mode 3 clamps to three words; the wdata word ends the frame.
  task automatic test_mode3();
    logic [3:0] exp [8] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
    bit to;
    int lasts = 0;
    mon_clear();
    bus.out_ready = 1'b1;
    push_rec(32'h1C000008, 32'h02800C0C, 32'hDEADBEEF, 2'd3);
    wait_idle(100, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL mode3_timeout got %b want 0", to); end
    n_assert++; if (mon_data.size() !== 24) begin n_fail++; $display("FAIL mode3_beats got %0d want 24", mon_data.size()); end
    for (int i = 0; i < mon_last.size(); i++) if (mon_last[i]) lasts++;
    n_assert++; if (lasts !== 1) begin n_fail++; $display("FAIL mode3_last_count got %0d want 1", lasts); end
    for (int i = 0; i < 8; i++) begin
      if (16 + i < mon_data.size()) begin
        n_assert++; if (mon_data[16+i] !== exp[i]) begin n_fail++; $display("FAIL mode3_digit[%0d] got %h want %h", 16 + i, mon_data[16+i], exp[i]); end
      end
    end
    if (mon_last.size() == 24) begin
      n_assert++; if (mon_last[23] !== 1'b1) begin n_fail++; $display("FAIL mode3_last_beat got %b want 1", mon_last[23]); end
    end
  endtask

  // A stalled in-flight primer frame keeps the FSM from popping, so of six
  // back-to-back records four are queued and two dropped.
  task automatic test_back_to_back();
    logic [3:0] exp_first [5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    bit to;
    mon_clear();
    bus.out_ready = 1'b0;
    push_rec(32'h1C000010, 32'h0, 32'h0, 2'd0);
    tick(); tick(); tick();
    for (int k = 1; k <= 6; k++) begin
      bus.in_valid = 1'b1;
      bus.in_words = {32'h0, 32'h0, 32'h1C000010 + 32'(k)};
      bus.mode     = 2'd0;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_words = '0;
    n_assert++; if (bus.drop_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_drop_cnt got %0d want 2", bus.drop_cnt); end
    n_assert++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
    n_assert++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_stalled got %b want 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    wait_idle(400, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout got %b want 0", to); end
    n_assert++; if (mon_data.size() !== 40) begin n_fail++; $display("FAIL b2b_beats got %0d want 40", mon_data.size()); end
    for (int f = 0; f < 5; f++) begin
      if (8 * f + 7 < mon_data.size()) begin
        n_assert++; if (mon_data[8*f] !== exp_first[f]) begin n_fail++; $display("FAIL b2b_frame%0d_d0 got %h want %h", f, mon_data[8*f], exp_first[f]); end
        n_assert++; if (mon_data[8*f+1] !== 4'h1) begin n_fail++; $display("FAIL b2b_frame%0d_d1 got %h want 1", f, mon_data[8*f+1]); end
        n_assert++; if (mon_last[8*f+7] !== 1'b1) begin n_fail++; $display("FAIL b2b_frame%0d_last got %b want 1", f, mon_last[8*f+7]); end
      end
    end
    n_assert++; if (bus.drop_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_drop_hold got %0d want 2", bus.drop_cnt); end
  endtask

  // Ready pattern 1,0,0,1 mid-frame, then a stall on the final beat.
  task automatic test_stall();
    bit to;
    int n;
    mon_clear();
    bus.out_ready = 1'b1;
    push_rec(32'h87654321, 32'h0, 32'h0, 2'd0);
    wait_valid(10, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_wait_valid got %b want 0", to); end
    tick();
    tick();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_assert++; if (bus.out_data !== 4'h3) begin n_fail++; $display("FAIL stall_mid_data[%0d] got %h want 3", c, bus.out_data); end
      n_assert++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL stall_mid_last[%0d] got %b want 0", c, bus.out_last); end
      if (c < 2) tick();
    end
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.out_last && n < 20) begin
      tick();
      n++;
    end
    bus.out_ready = 1'b0;
    n_assert++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL stall_reach_last got %b want 1", bus.out_last); end
    tick();
    n_assert++; if (bus.out_data !== 4'h8) begin n_fail++; $display("FAIL stall_end_data got %h want 8", bus.out_data); end
    n_assert++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL stall_end_last got %b want 1", bus.out_last); end
    bus.out_ready = 1'b1;
    wait_idle(50, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_timeout got %b want 0", to); end
    n_assert++; if (mon_data.size() !== 8) begin n_fail++; $display("FAIL stall_beats got %0d want 8", mon_data.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < mon_data.size()) begin
        n_assert++; if (mon_data[i] !== 4'(i + 1)) begin n_fail++; $display("FAIL stall_digit[%0d] got %h want %h", i, mon_data[i], 4'(i + 1)); end
      end
    end
  endtask

  // Reset asserted between clock edges while beat 5 is on the bus.
  task automatic test_reset_mid();
    logic [3:0] exp [8] = '{4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 4'h1};
    bit to;
    mon_clear();
    bus.out_ready = 1'b1;
    push_rec(32'h1C00000C, 32'h02800C0C, 32'h0, 2'd1);
    wait_valid(10, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL rstmid_wait_valid got %b want 0", to); end
    tick(); tick(); tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    n_assert++; if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_drop_cnt got %0d want 0", bus.drop_cnt); end
    n_assert++; if (bus.out_data !== 4'h0) begin n_fail++; $display("FAIL rstmid_out_data got %h want 0", bus.out_data); end
    tick();
    rst = 1'b0;
    tick();
    mon_clear();
    push_rec(32'h1C00000C, 32'h0, 32'h0, 2'd0);
    wait_idle(50, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout got %b want 0", to); end
    n_assert++; if (mon_data.size() !== 8) begin n_fail++; $display("FAIL rstmid_beats got %0d want 8", mon_data.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < mon_data.size()) begin
        n_assert++; if (mon_data[i] !== exp[i]) begin n_fail++; $display("FAIL rstmid_digit[%0d] got %h want %h", i, mon_data[i], exp[i]); end
      end
    end
  endtask

  task automatic test_pc_zero();
    mon_clear();
    bus.out_ready = 1'b1;
    push_rec(32'h0, 32'h11111111, 32'h22222222, 2'd2);
    tick(); tick(); tick();
    n_assert++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL pc0_busy got %b want 0", bus.busy); end
    n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL pc0_valid got %b want 0", bus.out_valid); end
    n_assert++; if (mon_data.size() !== 0) begin n_fail++; $display("FAIL pc0_beats got %0d want 0", mon_data.size()); end
    n_assert++; if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL pc0_drop_cnt got %0d want 0", bus.drop_cnt); end
  endtask

  task automatic test_dedup();
    bit to;
    int frames = 0;
`ifdef DEBUG_TRACE_DEDUP_EN
    int exp_frames = 1;
`else
    int exp_frames = 2;
`endif
    mon_clear();
    bus.out_ready = 1'b1;
    push_rec(32'h1C000004, 32'h0, 32'h0, 2'd0);
    push_rec(32'h1C000004, 32'h0, 32'h0, 2'd0);
    wait_idle(100, to);
    n_assert++; if (to !== 1'b0) begin n_fail++; $display("FAIL dedup_timeout got %b want 0", to); end
    for (int i = 0; i < mon_last.size(); i++) if (mon_last[i]) frames++;
    n_assert++; if (frames !== exp_frames) begin n_fail++; $display("FAIL dedup_frames got %0d want %0d", frames, exp_frames); end
    n_assert++; if (mon_data.size() !== 8 * exp_frames) begin n_fail++; $display("FAIL dedup_beats got %0d want %0d", mon_data.size(), 8 * exp_frames); end
    n_assert++; if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL dedup_drop_cnt got %0d want 0", bus.drop_cnt); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_words  = '0;
    bus.mode      = 2'd0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_single();
    test_mode3();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_pc_zero();
    test_dedup();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
